// File: rtl/reset_pulse_gen.sv
// reset_pulse_gen
// Reset sequencer for one clock domain. It drives a stretched reset pulse on both
// polarities, then runs a hold-off window, then raises ready. A level-sensitive
// request restarts or extends the pulse. Completed pulses are counted, and the
// count saturates at 255.
module reset_pulse_gen #(
   parameter int STRETCH = 8,
   parameter int HOLDOFF = 4,
   parameter int CW      = $clog2((STRETCH > HOLDOFF) ? STRETCH : HOLDOFF) + 1
) (
   input  logic       clk,
   input  logic       sync_reset,
   input  logic       req,
   output logic       rst_high,
   output logic       rst_low,
   output logic       busy,
   output logic       ready,
   output logic [7:0] pulse_count
);

   localparam logic [1:0] ST_ASSERT = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_IDLE   = 2'd2;

   // Terminal counter values. The counter runs 0..N-1, so every state lasts at least one cycle.
   localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
   localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF - 1);

   logic [1:0]    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [7:0]    count_reg, count_next;

   // Next-state, counter and pulse-count logic for the ASSERT -> HOLD -> IDLE sequence.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      count_next = count_reg;
      case (state_reg)
         ST_ASSERT: begin
            if (req) begin
               // A request that is still held keeps the pulse stretched.
               cnt_next = '0;
            end else if (cnt_reg == STRETCH_LAST) begin
               state_next = ST_HOLD;
               cnt_next   = '0;
               if (count_reg != 8'hFF) begin
                  count_next = count_reg + 8'd1;
               end
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_HOLD: begin
            if (req) begin
               // An aborted hold-off is not a new pulse, so the count is unchanged.
               state_next = ST_ASSERT;
               cnt_next   = '0;
            end else if (cnt_reg == HOLDOFF_LAST) begin
               state_next = ST_IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         ST_IDLE: begin
            if (req) begin
               state_next = ST_ASSERT;
               cnt_next   = '0;
            end
         end
         default: begin
            // An unreachable encoding recovers by starting a fresh reset pulse.
            state_next = ST_ASSERT;
            cnt_next   = '0;
         end
      endcase
   end

   // State registers. A synchronous reset restarts the whole sequence and clears the pulse count.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_reg <= ST_ASSERT;
         cnt_reg   <= '0;
         count_reg <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         count_reg <= count_next;
      end
   end

   // Outputs are decoded directly from the registered state, so they cannot glitch relative to each other.
   always_comb begin
      rst_high    = (state_reg == ST_ASSERT);
      rst_low     = ~rst_high;
      busy        = (state_reg != ST_IDLE);
      ready       = (state_reg == ST_IDLE);
      pulse_count = count_reg;
   end

endmodule
